// File: rtl/ntt_sched_pkg.sv
// Shared types and elaboration helpers for the NTT stage scheduler.
// Holds the FSM encoding, the read-to-write pipeline depth and a clog2 for port widths.
package ntt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Cycles from a read strobe to the matching write-back strobe.
    function automatic int pipe_delay(input int rd_lat, input int bfu_lat);
        return rd_lat + bfu_lat;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// DEPTH x WIDTH shift register with asynchronous clear.
// Exposes the full-depth output plus bit 0 of stage TAP (used as an early valid tap).
module ntt_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    parameter int TAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tap_lsb
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
        end
    endgenerate

    assign dout    = g_stage[DEPTH-1].q_reg;
    assign tap_lsb = g_stage[TAP-1].q_reg[0];

endmodule

// File: rtl/ntt_stage_sched.sv
// Address/strobe sequencer for an in-place N-point NTT/INTT on a ping-pong RAM pair.
// Issues one butterfly per cycle per stage, then drains the RAM+BFU pipeline before the next stage.
module ntt_stage_sched
    import ntt_sched_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     inv,
    output logic                     busy,
    output logic                     done,
    output logic [clog2(LOGN)-1:0]   stage,
    output logic                     rd_en,
    output logic                     rd_bank,
    output logic [LOGN-1:0]          rd_addr0,
    output logic [LOGN-1:0]          rd_addr1,
    output logic [LOGN:0]            tw_addr,
    output logic                     bfu_en,
    output logic                     wr_en,
    output logic                     wr_bank,
    output logic [LOGN-1:0]          wr_addr0,
    output logic [LOGN-1:0]          wr_addr1
);

    localparam int N  = 1 << LOGN;
    localparam int D  = pipe_delay(RD_LAT, BFU_LAT);
    localparam int SW = clog2(LOGN);
    localparam int CW = (D > 1) ? clog2(D) : 1;
    localparam int DW = 2 + 2 * LOGN;

    localparam logic [LOGN-1:0] K_LAST   = LOGN'(N / 2 - 1);
    localparam logic [SW-1:0]   S_LAST   = SW'(LOGN - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(D - 1);
    localparam logic [LOGN-1:0] ONE      = LOGN'(1);

    sched_state_t    state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [LOGN-1:0] k_reg, k_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            inv_reg, inv_next;

    logic            rd_en_reg, busy_reg, done_reg;
    logic [LOGN-1:0] rd_addr0_reg, rd_addr1_reg;
    logic [LOGN:0]   tw_addr_reg;

    logic [SW-1:0]   span_sh, tw_sh;
    logic [LOGN-1:0] grp, ofs, addr0_next, addr1_next, tw_idx;
    logic            issue_next;

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        k_next     = k_reg;
        cnt_next   = cnt_reg;
        inv_next   = inv_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                    inv_next   = inv;
                    s_next     = '0;
                    k_next     = '0;
                end
            end
            ST_ISSUE: begin
                if (k_reg == K_LAST) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    k_next = k_reg + ONE;
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == CNT_LAST) begin
                    if (s_reg == S_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                        s_next     = s_reg + SW'(1);
                        k_next     = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Addresses are formed from the next-state counters so the registered outputs line up with ISSUE.
    always_comb begin
        issue_next = (state_next == ST_ISSUE);
        span_sh    = inv_next ? s_next : (S_LAST - s_next);
        tw_sh      = inv_next ? (S_LAST - s_next) : s_next;
        ofs        = k_next & ((ONE << span_sh) - ONE);
        grp        = k_next >> span_sh;
        addr0_next = ((grp << span_sh) << 1) | ofs;
        addr1_next = addr0_next | (ONE << span_sh);
        tw_idx     = (ONE << tw_sh) | grp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            s_reg        <= '0;
            k_reg        <= '0;
            cnt_reg      <= '0;
            inv_reg      <= 1'b0;
            rd_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_addr0_reg <= '0;
            rd_addr1_reg <= '0;
            tw_addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            k_reg     <= k_next;
            cnt_reg   <= cnt_next;
            inv_reg   <= inv_next;
            rd_en_reg <= issue_next;
            busy_reg  <= (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
            done_reg  <= (state_next == ST_DONE);
            if (issue_next) begin
                rd_addr0_reg <= addr0_next;
                rd_addr1_reg <= addr1_next;
                tw_addr_reg  <= {inv_next, tw_idx};
            end
        end
    end

    logic [DW-1:0] dl_in, dl_out;

    assign dl_in = {rd_addr1_reg, rd_addr0_reg, ~s_reg[0], rd_en_reg};

    ntt_delay_line #(
        .DEPTH (D),
        .WIDTH (DW),
        .TAP   (RD_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (dl_in),
        .dout    (dl_out),
        .tap_lsb (bfu_en)
    );

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign stage    = s_reg;
    assign rd_en    = rd_en_reg;
    assign rd_bank  = s_reg[0];
    assign rd_addr0 = rd_addr0_reg;
    assign rd_addr1 = rd_addr1_reg;
    assign tw_addr  = tw_addr_reg;
    assign wr_en    = dl_out[0];
    assign wr_bank  = dl_out[1];
    assign wr_addr0 = dl_out[2 +: LOGN];
    assign wr_addr1 = dl_out[2 + LOGN +: LOGN];

endmodule
